// File: rtl/regfile_seq_pkg.sv
// Shared constants for the register-file sequencer: widths, opcodes,
// instruction field positions and FSM state encoding.
package regfile_seq_pkg;

  localparam int SEQ_DATA_W = 10;
  localparam int SEQ_ADDR_W = 3;
  localparam int SEQ_CNT_W  = 8;

  // Instruction layout: op[9:8] rd[7:6] rs1[5:3] rs2[2:0]; LI uses [5:0] as imm
  localparam int OP_HI  = 9;
  localparam int OP_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 6;
  localparam int RS1_HI = 5;
  localparam int RS1_LO = 3;
  localparam int RS2_HI = 2;
  localparam int RS2_LO = 0;
  localparam int IMM_W  = 6;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_LI  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Instruction handshake plus register-file port set. The sequencer is the
// master (initiator); the instruction source / register file side is the slave.
interface regfile_sequencer_if;
  import regfile_seq_pkg::*;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [SEQ_DATA_W-1:0] instr;
  logic                  rf_we;
  logic [SEQ_ADDR_W-1:0] rf_waddr;
  logic [SEQ_DATA_W-1:0] rf_wdata;
  logic [SEQ_ADDR_W-1:0] rf_raddr1;
  logic [SEQ_ADDR_W-1:0] rf_raddr2;
  logic [SEQ_DATA_W-1:0] rf_rdata1;
  logic [SEQ_DATA_W-1:0] rf_rdata2;

  modport master (
    input  instr_valid, instr, rf_rdata1, rf_rdata2,
    output instr_ready, rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2
  );

  modport slave (
    output instr_valid, instr, rf_rdata1, rf_rdata2,
    input  instr_ready, rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2
  );

endinterface

// File: rtl/rf_seq_alu.sv
// Combinational 10-bit ALU: ADD/SUB with carry/borrow, AND, load-immediate.
module rf_seq_alu
  import regfile_seq_pkg::*;
(
  input  op_e                   op,
  input  logic [SEQ_DATA_W-1:0] a,
  input  logic [SEQ_DATA_W-1:0] b,
  input  logic [IMM_W-1:0]      imm,
  output logic [SEQ_DATA_W-1:0] y,
  output logic                  carry
);

  logic [SEQ_DATA_W:0] sum;

  // Result and carry per opcode; carry only meaningful for ADD/SUB
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        y     = sum[SEQ_DATA_W-1:0];
        carry = sum[SEQ_DATA_W];
      end
      OP_SUB: begin
        y     = a - b;
        carry = (a < b);
      end
      OP_AND:  y = a & b;
      default: y = {{(SEQ_DATA_W-IMM_W){1'b0}}, imm};
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Serialised instruction sequencer in front of an 8x10-bit register file.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | ready for an instruction; latch it on valid
//   ST_READ  | read addresses driven from latched rs1/rs2; capture operands
//   ST_EXEC  | ALU evaluates captured operands; result registered
//   ST_WRITE | write-back to {1'b0,rd}, done pulse, status/counter update
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_sequencer_if.master   bus,
  output logic                  done,
  output logic [SEQ_DATA_W-1:0] result,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic [CNT_W-1:0]      instr_count
);

  state_e                state, state_nxt;
  logic [SEQ_DATA_W-1:0] instr_q;
  logic [SEQ_DATA_W-1:0] opa_q, opb_q;
  logic [SEQ_DATA_W-1:0] alu_y, alu_y_q;
  logic                  alu_c, alu_c_q;
  op_e                   op;

  assign op            = op_e'(instr_q[OP_HI:OP_LO]);
  assign bus.rf_raddr1 = instr_q[RS1_HI:RS1_LO];
  assign bus.rf_raddr2 = instr_q[RS2_HI:RS2_LO];
  assign bus.rf_waddr  = {1'b0, instr_q[RD_HI:RD_LO]};
  assign bus.rf_wdata  = alu_y_q;

  rf_seq_alu u_alu (
    .op    (op),
    .a     (opa_q),
    .b     (opb_q),
    .imm   (instr_q[IMM_W-1:0]),
    .y     (alu_y),
    .carry (alu_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake / write strobes; one cycle per non-idle state
  always_comb begin
    state_nxt       = state;
    bus.instr_ready = 1'b0;
    bus.rf_we       = 1'b0;
    done            = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_nxt = ST_READ;
      end
      ST_READ:  state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_WRITE;
      ST_WRITE: begin
        bus.rf_we = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers; status moves in lock-step with the register-file write
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      alu_y_q     <= '0;
      alu_c_q     <= 1'b0;
      result      <= '0;
      zero_flag   <= 1'b1;
      carry_flag  <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.instr_valid) instr_q <= bus.instr;
        ST_READ: begin
          opa_q <= bus.rf_rdata1;
          opb_q <= bus.rf_rdata2;
        end
        ST_EXEC: begin
          alu_y_q <= alu_y;
          alu_c_q <= alu_c;
        end
        ST_WRITE: begin
          result      <= alu_y_q;
          zero_flag   <= (alu_y_q == '0);
          carry_flag  <= alu_c_q;
          instr_count <= instr_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file on the slave side,
// transaction-level reference model, directed cases then random instructions.
module tb_regfile_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done;
  logic [9:0] result;
  logic       zero_flag;
  logic       carry_flag;
  logic [7:0] instr_count;

  int n_chk  = 0;
  int n_pass = 0;
  int done_seen = 0;

  logic [9:0] rf_mem [0:7] = '{default: '0};

  int ref_rf [0:7];
  int ref_result;
  int ref_zero;
  int ref_carry;
  int ref_count;

  regfile_sequencer_if bus ();

  regfile_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .done        (done),
    .result      (result),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Register file: combinational reads, write on rising edge
  assign bus.rf_rdata1 = rf_mem[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf_mem[bus.rf_raddr2];

  always @(posedge clk) begin
    if (bus.rf_we) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
  end

  // Count done pulses since the last reset
  always @(posedge clk) begin
    if (rst)       done_seen <= 0;
    else if (done) done_seen <= done_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [9:0] enc(input int op, input int rd, input int rs1, input int rs2);
    logic [9:0] w;
    w = {op[1:0], rd[1:0], rs1[2:0], rs2[2:0]};
    return w;
  endfunction

  function automatic logic [9:0] enc_li(input int rd, input int imm);
    logic [9:0] w;
    w = {2'b11, rd[1:0], imm[5:0]};
    return w;
  endfunction

  task automatic model_reset();
    ref_result = 0;
    ref_zero   = 1;
    ref_carry  = 0;
    ref_count  = 0;
  endtask

  // Issue one instruction and check it end to end against the model
  task automatic run_instr(input logic [9:0] w);
    int op, rd, a, b, y, c, s, waits, lat;
    op = int'(w[9:8]);
    rd = int'(w[7:6]);
    a  = ref_rf[w[5:3]];
    b  = ref_rf[w[2:0]];
    case (op)
      0:       begin s = a + b; y = s % 1024; c = (s >= 1024) ? 1 : 0; end
      1:       begin y = (a - b + 1024) % 1024; c = (a < b) ? 1 : 0; end
      2:       begin y = a & b; c = 0; end
      default: begin y = int'(w[5:0]); c = 0; end
    endcase

    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    waits = 0;
    while (!bus.instr_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    chk("accept_wait", (waits < 10) ? 1 : 0, 1);

    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 10'($urandom);
    chk("ready_busy", bus.instr_ready, 0);
    chk("raddr1", bus.rf_raddr1, w[5:3]);
    chk("raddr2", bus.rf_raddr2, w[2:0]);

    lat = 1;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    chk("rf_we", bus.rf_we, 1);
    chk("waddr", bus.rf_waddr, rd);
    chk("wdata", bus.rf_wdata, y);

    ref_rf[rd] = y;
    ref_result = y;
    ref_zero   = (y == 0) ? 1 : 0;
    ref_carry  = c;
    ref_count  = (ref_count + 1) % 256;

    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("we_pulse", bus.rf_we, 0);
    chk("ready_back", bus.instr_ready, 1);
    chk("result", result, ref_result);
    chk("zero", zero_flag, ref_zero);
    chk("carry", carry_flag, ref_carry);
    chk("count", instr_count, ref_count);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepts;
    logic [9:0] held_w;
    logic [9:0] r2_before;

    for (int i = 0; i < 8; i++) ref_rf[i] = 0;
    model_reset();
    bus.instr_valid = 1'b0;
    bus.instr       = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero_flag, 1);
    chk("rst_carry", carry_flag, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_raddr1", bus.rf_raddr1, 0);

    // Directed arithmetic sequence
    run_instr(enc_li(1, 5));
    chk("li_r1", rf_mem[1], 5);
    run_instr(enc_li(2, 63));
    run_instr(enc(0, 3, 1, 2));
    chk("add_r3", rf_mem[3], 68);
    chk("add_carry", carry_flag, 0);
    run_instr(enc(1, 0, 0, 1));
    chk("sub_r0", rf_mem[0], 10'h3FB);
    chk("sub_borrow", carry_flag, 1);
    run_instr(enc(0, 0, 0, 1));
    chk("wrap_r0", rf_mem[0], 0);
    chk("wrap_zero", zero_flag, 1);
    chk("wrap_carry", carry_flag, 1);

    // Valid held high for 12 cycles: accepts only when idle
    held_w = enc_li(2, 7);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = held_w;
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      chk("held_ready", bus.instr_ready, (i % 4 == 0) ? 1 : 0);
      if (bus.instr_ready) accepts++;
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    chk("held_accepts", accepts, 3);
    ref_rf[2]  = 7;
    ref_result = 7;
    ref_zero   = 0;
    ref_carry  = 0;
    ref_count  = (ref_count + 3) % 256;
    chk("held_count", instr_count, ref_count);
    chk("held_r2", rf_mem[2], 7);

    // AND with an unwritten high register
    run_instr(enc(2, 1, 1, 5));
    chk("and_r5", rf_mem[1], 0);

    // Reset during EXEC aborts the write-back
    r2_before = rf_mem[2];
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = enc(0, 2, 3, 3);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", bus.rf_we, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_ready", bus.instr_ready, 1);
    chk("abort_we2", bus.rf_we, 0);
    chk("abort_count", instr_count, 0);
    chk("abort_result", result, 0);
    chk("abort_zero", zero_flag, 1);
    chk("abort_raddr", bus.rf_raddr1, 0);
    chk("abort_r2", rf_mem[2], r2_before);
    chk("abort_r2_model", rf_mem[2], ref_rf[2]);

    // 256 random instructions with random idle gaps: counter wraps to 0
    for (int k = 0; k < 256; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_instr(10'($urandom_range(0, 1023)));
    end
    chk("wrap_count", instr_count, 0);
    chk("done_pulses", done_seen, 256);
    for (int i = 0; i < 8; i++) chk("final_rf", rf_mem[i], ref_rf[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
